// File: rtl/dm_access_unit.sv
// MEM-stage data-memory responder: big-endian byte array with byte/halfword/word access,
// configurable wait latency and load extension. Optional DM_MISALIGN_TRAP_EN enables alignment faults.
module dm_access_unit #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              R,
  input  logic              E_mem,
  input  logic              rw_dm_mem,
  input  logic [1:0]        size_mem,
  input  logic              se_mem,
  input  logic [31:0]       addr_mem,
  input  logic [31:0]       wdata_mem,
  input  logic              pl_we,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [7:0]        pl_data,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              fault;
  logic [ADDR_W-1:0] a_q;
  logic [1:0]        size_q;
  logic              rw_q;
  logic              se_q;
  logic [31:0]       wdata_q;

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  logic              misaligned;
  logic [ADDR_W-1:0] eff_addr;
  logic [1:0]        eff_size;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr_mem[31:ADDR_W];

  always_comb begin
    eff_addr = addr_mem[ADDR_W-1:0];
`ifdef DM_MISALIGN_TRAP_EN
    eff_size   = size_mem;
    misaligned = (size_mem == 2'b11) ||
                 (size_mem == 2'b01 && addr_mem[0]) ||
                 (size_mem == 2'b10 && addr_mem[1:0] != 2'b00);
`else
    // Without trapping, misaligned requests are silently aligned down; size 11 acts as word.
    misaligned = 1'b0;
    eff_size   = (size_mem == 2'b11) ? 2'b10 : size_mem;
    if (eff_size == 2'b01) eff_addr[0] = 1'b0;
    if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
  end

  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       ld_val;
  logic              access;

  assign a1 = a_q + ADDR_W'(1);
  assign a2 = a_q + ADDR_W'(2);
  assign a3 = a_q + ADDR_W'(3);
  assign b0 = mem[a_q];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    case (size_q)
      2'b00:   ld_val = se_q ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   ld_val = se_q ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
      default: ld_val = {b0, b1, b2, b3};
    endcase
  end

  assign access = (state == S_BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (R) begin
      state   <= S_IDLE;
      cnt     <= '0;
      fault   <= 1'b0;
      rdata   <= '0;
      a_q     <= '0;
      size_q  <= '0;
      rw_q    <= 1'b0;
      se_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (E_mem) begin
            if (misaligned) begin
              fault <= 1'b1;
              state <= S_DONE;
              if (!rw_dm_mem) rdata <= '0;
            end else begin
              a_q     <= eff_addr;
              size_q  <= eff_size;
              rw_q    <= rw_dm_mem;
              se_q    <= se_mem;
              wdata_q <= wdata_mem;
              cnt     <= 4'(WAIT_CYCLES);
              fault   <= 1'b0;
              state   <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!rw_q) rdata <= ld_val;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          fault <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array has no reset; R only blocks writes so an aborted store leaves memory intact.
  always_ff @(posedge clk) begin
    if (!R) begin
      if (access && rw_q) begin
        case (size_q)
          2'b00: mem[a_q] <= wdata_q[7:0];
          2'b01: begin
            mem[a_q] <= wdata_q[15:8];
            mem[a1]  <= wdata_q[7:0];
          end
          default: begin
            mem[a_q] <= wdata_q[31:24];
            mem[a1]  <= wdata_q[23:16];
            mem[a2]  <= wdata_q[15:8];
            mem[a3]  <= wdata_q[7:0];
          end
        endcase
      end else if (state == S_IDLE && !E_mem && pl_we) begin
        mem[pl_addr] <= pl_data;
      end
    end
  end

  assign done     = (state == S_DONE);
  assign stall    = E_mem & ~done;
`ifdef DM_MISALIGN_TRAP_EN
  assign misalign = done & fault;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dm_access_unit.sv
// Scoreboard bench for dm_access_unit: stimulus pushes expected done-responses, a monitor checks them.
module tb_dm_access_unit;

  localparam int AW = 9;
  localparam int WC = 1;
  localparam int unsigned ST_OK = WC + 2;

  logic          clk = 1'b0;
  logic          R = 1'b1;
  logic          E_mem = 1'b0;
  logic          rw_dm_mem = 1'b0;
  logic [1:0]    size_mem = 2'b00;
  logic          se_mem = 1'b0;
  logic [31:0]   addr_mem = '0;
  logic [31:0]   wdata_mem = '0;
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [7:0]    pl_data = '0;
  logic [31:0]   rdata;
  logic          stall;
  logic          done;
  logic          misalign;

  dm_access_unit #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .R(R), .E_mem(E_mem), .rw_dm_mem(rw_dm_mem), .size_mem(size_mem),
    .se_mem(se_mem), .addr_mem(addr_mem), .wdata_mem(wdata_mem), .pl_we(pl_we),
    .pl_addr(pl_addr), .pl_data(pl_data), .rdata(rdata), .stall(stall),
    .done(done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        mis;
    int unsigned st;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int unsigned scnt = 0;
  int pushed = 0;
  int popped = 0;

`ifdef DM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: counts stall cycles per access and checks each done pulse against the queue head.
  always @(negedge clk) begin
    if (R) begin
      scnt = 0;
    end else begin
      if (stall) scnt++;
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = q.pop_front();
          popped++;
          chk({e.name, "_rdata"}, rdata, e.rd);
          chk({e.name, "_misalign"}, {31'b0, misalign}, {31'b0, e.mis});
          chk({e.name, "_stall"}, scnt, e.st);
        end
        scnt = 0;
      end
    end
  end

  task automatic access(input string name, input logic rw, input logic [1:0] sz, input logic se,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input int unsigned exp_st);
    exp_t e;
    bit seen;
    e.name = name; e.rd = exp_rd; e.mis = exp_mis; e.st = exp_st;
    q.push_back(e);
    pushed++;
    @(posedge clk); #1;
    E_mem = 1'b1; rw_dm_mem = rw; size_mem = sz; se_mem = se; addr_mem = addr; wdata_mem = wd;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    E_mem = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 R = 1'b0;
    @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_misalign", {31'b0, misalign}, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'h0);

    // Word store/load and big-endian byte order, issued back-to-back.
    access("st_w_010", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0, ST_OK);
    access("ld_w_010", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0, ST_OK);
    access("ld_b_010", 1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 32'h000000DE, 1'b0, ST_OK);
    access("ld_b_011", 1'b0, 2'b00, 1'b0, 32'h011, 32'h0, 32'h000000AD, 1'b0, ST_OK);
    access("ld_b_012", 1'b0, 2'b00, 1'b0, 32'h012, 32'h0, 32'h000000BE, 1'b0, ST_OK);
    access("ld_b_013", 1'b0, 2'b00, 1'b0, 32'h013, 32'h0, 32'h000000EF, 1'b0, ST_OK);

    idle();
    preload(9'h020, 8'h80);
    access("ld_b_se1", 1'b0, 2'b00, 1'b1, 32'h020, 32'h0, 32'hFFFFFF80, 1'b0, ST_OK);
    access("ld_b_se0", 1'b0, 2'b00, 1'b0, 32'h020, 32'h0, 32'h00000080, 1'b0, ST_OK);

    access("st_h_032", 1'b1, 2'b01, 1'b0, 32'h032, 32'hFFFF1234, 32'h00000080, 1'b0, ST_OK);
    access("ld_b_032", 1'b0, 2'b00, 1'b0, 32'h032, 32'h0, 32'h00000012, 1'b0, ST_OK);
    access("ld_b_033", 1'b0, 2'b00, 1'b0, 32'h033, 32'h0, 32'h00000034, 1'b0, ST_OK);
    access("ld_h_032", 1'b0, 2'b01, 1'b1, 32'h032, 32'h0, 32'h00001234, 1'b0, ST_OK);
    access("st_h_034", 1'b1, 2'b01, 1'b0, 32'h034, 32'h00008001, 32'h00001234, 1'b0, ST_OK);
    access("ld_h_034", 1'b0, 2'b01, 1'b1, 32'h034, 32'h0, 32'hFFFF8001, 1'b0, ST_OK);

    idle();
    preload(9'h040, 8'h01);
    preload(9'h041, 8'h02);
    preload(9'h042, 8'h03);
    preload(9'h043, 8'h04);
    if (TRAP) begin
      access("ld_w_041", 1'b0, 2'b10, 1'b0, 32'h041, 32'h0, 32'h0, 1'b1, 1);
      access("st_w_043", 1'b1, 2'b10, 1'b0, 32'h043, 32'hCAFEF00D, 32'h0, 1'b1, 1);
      access("ld_w_040", 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 32'h01020304, 1'b0, ST_OK);
      access("ld_s11_040", 1'b0, 2'b11, 1'b0, 32'h040, 32'h0, 32'h0, 1'b1, 1);
      access("ld_h_035", 1'b0, 2'b01, 1'b0, 32'h035, 32'h0, 32'h0, 1'b1, 1);
    end else begin
      access("ld_w_041", 1'b0, 2'b10, 1'b0, 32'h041, 32'h0, 32'h01020304, 1'b0, ST_OK);
      access("st_w_043", 1'b1, 2'b10, 1'b0, 32'h043, 32'hCAFEF00D, 32'h01020304, 1'b0, ST_OK);
      access("ld_w_040", 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 32'hCAFEF00D, 1'b0, ST_OK);
      access("ld_s11_040", 1'b0, 2'b11, 1'b0, 32'h040, 32'h0, 32'hCAFEF00D, 1'b0, ST_OK);
      access("ld_h_035", 1'b0, 2'b01, 1'b0, 32'h035, 32'h0, 32'h00008001, 1'b0, ST_OK);
    end

    // Reset mid-access: store begins at cycle 0, R asserted during cycle 2.
    access("st_w_050", 1'b1, 2'b10, 1'b0, 32'h050, 32'h11111111, TRAP ? 32'h0 : 32'h00008001, 1'b0, ST_OK);
    idle();
    @(posedge clk); #1;
    E_mem = 1'b1; rw_dm_mem = 1'b1; size_mem = 2'b10; addr_mem = 32'h050; wdata_mem = 32'hAAAAAAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    R = 1'b1; E_mem = 1'b0;
    @(posedge clk); #1;
    R = 1'b0;
    @(negedge clk);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_stall", {31'b0, stall}, 32'h0);
    access("ld_w_050", 1'b0, 2'b10, 1'b0, 32'h050, 32'h0, 32'h11111111, 1'b0, ST_OK);

    // Upper address bits ignored: 0x201 aliases 0x001.
    access("st_b_201", 1'b1, 2'b00, 1'b0, 32'h00000201, 32'h0000005A, 32'h11111111, 1'b0, ST_OK);
    access("ld_b_001", 1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 32'h0000005A, 1'b0, ST_OK);
    idle();

    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 32'h0);
    chk("done_count", popped, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

MEM-stage data-memory responder for the SPARC pipeline. Consumes the memory-control bundle produced by the EX/MEM register: enable, read/write, size, plus a sign-extend flag, address and store data. It performs the byte, halfword or word access on an internal big-endian byte-addressed array. It stalls the pipeline for a configurable wait latency and returns load data with sign or zero extension.

## Interface
Parameters:
- `ADDR_W`, default 9: byte-address width of the internal array (2^ADDR_W bytes). Upper address bits are ignored, so addresses wrap modulo array size.
- `WAIT_CYCLES`, default 1: extra BUSY cycles per access. Legal range 0–15.

Ports:
- `clk`  in  1: clock. All state updates on the rising edge.
- `R`  in  1: reset, synchronous, active-high.
- `E_mem`  in  1: access request; held by the pipeline until `done`.
- `rw_dm_mem`  in  1: 0 = load, 1 = store.
- `size_mem`  in  2: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `se_mem`  in  1: load sign-extend (1) or zero-extend (0).
- `addr_mem`  in  32: byte address.
- `wdata_mem`  in  32: store data, right-justified.
- `pl_we`  in  1: testbench/boot preload byte write.
- `pl_addr`  in  ADDR_W: preload address.
- `pl_data`  in  8: preload byte.
- `rdata`  out  32: load result.
- `stall`  out  1: hold IF..MEM pipeline registers.
- `done`  out  1: one-cycle completion pulse.
- `misalign`  out  1: alignment fault, valid with `done`.

## Operation
- States: IDLE, BUSY, DONE. A 4-bit wait counter is used in BUSY.
- IDLE with `E_mem`=1 and an aligned request: latch addr, size, rw, se and wdata, load counter = `WAIT_CYCLES`, then go to BUSY.
- Alignment rules: halfword needs addr[0]=0; word needs addr[1:0]=00; size 11 is always misaligned.
- IDLE with `E_mem`=1 and a misaligned request: no array access. Go to DONE with a fault flag set.
- BUSY: if counter≠0, decrement and stay. If counter=0, perform the access at that edge and go to DONE.
- DONE: `done`=1. `misalign` equals the fault flag. Next state is IDLE unconditionally.
- Store layout (big-endian, a = latched addr):
  - byte: mem[a]=wdata[7:0].
  - halfword: mem[a]=wdata[15:8], mem[a+1]=wdata[7:0].
  - word: mem[a..a+3]=wdata[31:24], [23:16], [15:8], [7:0].
- Load assembly uses the same byte order. Byte and halfword results are extended to 32 bits per the latched `se`.
- `rdata` is updated only on a completed load. It holds its value through stores, faults and idle cycles. A faulted load writes `rdata`=0.
- `stall` = `E_mem` & ~`done` (combinational).
- Preload: `pl_we` writes `pl_data` to mem[`pl_addr`] only when state=IDLE and `E_mem`=0. Otherwise it is ignored.
- Array contents are not cleared by `R`.

## Timing
- Request first seen in IDLE at cycle 0.
- BUSY occupies cycles 1..WAIT_CYCLES+1. DONE occurs at cycle WAIT_CYCLES+2.
- `stall` is high for cycles 0..WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles.
- Store data is visible to a load issued in the cycle after DONE.
- Misaligned request: DONE at cycle 1, `stall` high for cycle 0 only.
- Back-to-back: a new request arriving in the cycle after DONE is accepted immediately from IDLE. There are no bubble cycles beyond the IDLE accept cycle.
- Reset values: state=IDLE, counter=0, `rdata`=0, `done`=0, `misalign`=0, fault flag=0.
- `R` during BUSY aborts the access: a store is not performed and `rdata` is cleared. `R` has priority over all other inputs.
- `E_mem` dropping while BUSY does not cancel the access; it completes normally. The pipeline never does this.

## Configuration
- `DM_MISALIGN_TRAP_EN` defined:
  - Alignment check is active as described above.
  - `misalign` pulses with `done` on a fault.
  - Faulted stores leave memory unchanged.
- `DM_MISALIGN_TRAP_EN` undefined:
  - addr[0] is forced to 0 for halfword accesses and addr[1:0] to 00 for word accesses.
  - size 11 is treated as word.
  - Every request proceeds through BUSY, and `misalign` is tied to 0.

## Test plan
- Word store, WAIT_CYCLES=1: store 0xDEADBEEF at 0x010, then load word at 0x010. Required: `rdata`=0xDEADBEEF; bytes 0x010..0x013 = DE, AD, BE, EF; `stall` high exactly 3 cycles per access.
- Byte load extension: preload mem[0x020]=0x80. Byte load with se=1 gives `rdata`=0xFFFFFF80; with se=0 it gives 0x00000080.
- Halfword endianness: store halfword 0x1234 at 0x032. Byte loads at 0x032 and 0x033 return 0x12 and 0x34. A halfword load with se=1 returns 0x00001234.
- Misaligned word load at 0x041 with the macro defined: `done` and `misalign` high at cycle 1, `rdata`=0, memory unchanged. With the macro undefined: the word at 0x040 is returned and `misalign`=0.
- Reset mid-access, WAIT_CYCLES=3: store 0xAAAAAAAA at 0x050 over prior 0x11111111, asserting `R` at cycle 2. Required: state=IDLE, `done` never pulses, and a later load at 0x050 returns 0x11111111.
- Address wrap, ADDR_W=9: store byte 0x5A at 0x00000201. A byte load at 0x001 returns 0x5A.
